axis_xgmii_rx_ctrl: RTL and testbench

//  Receive-enable sequencer and frame statistics engine for the 128-bit XGMII receiver.
//  - Turns the software enable request into the receiver's cfg_rx_enable, but only after the line has been quiet.
//  - Tracks frame boundaries from the receiver's AXI output and status pulses.
//  - Auto-disables the receiver when bad frames arrive at a storm rate, and counts good, FCS-error and framing-error frames.

---
 rtl/axis_xgmii_rx_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_axis_xgmii_rx_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_xgmii_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axis_xgmii_rx_ctrl
// Purpose  : Receive-enable sequencer and frame statistics engine for the
//            128-bit XGMII receiver. Gates the software enable request behind
//            a quiet-line interval, drains in-flight frames on disable,
//            auto-disables on an error storm and keeps saturating frame counts.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            rx_enable_req            - software enable request
//            fault_clear, stat_clear  - single-cycle clear pulses
//            mon_axis_tvalid/tlast    - receiver AXI output monitor
//            mon_start_packet[1:0]    - receiver start_packet monitor
//            mon_error_bad_frame/fcs  - receiver error status pulses
//            cfg_rx_enable            - registered receiver enable
//            status_state[1:0]        - 0 DISABLED, 1 WAIT_IDLE, 2 ENABLED, 3 DRAIN
//            status_rx_active         - state is not DISABLED
//            status_fault             - sticky error-storm fault
//            stat_frames_good/bad_fcs/bad - saturating frame counters
// Revision : 1.0 - initial release
// ============================================================================
module axis_xgmii_rx_ctrl #(
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned IDLE_CYCLES = 16,
   parameter int unsigned ERR_WINDOW  = 1024,
   parameter int unsigned ERR_THRESH  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_enable_req,
   input  logic                 fault_clear,
   input  logic                 stat_clear,
   input  logic                 mon_axis_tvalid,
   input  logic                 mon_axis_tlast,
   input  logic [1:0]           mon_start_packet,
   input  logic                 mon_error_bad_frame,
   input  logic                 mon_error_bad_fcs,
   output logic                 cfg_rx_enable,
   output logic [1:0]           status_state,
   output logic                 status_rx_active,
   output logic                 status_fault,
   output logic [CNT_WIDTH-1:0] stat_frames_good,
   output logic [CNT_WIDTH-1:0] stat_frames_bad_fcs,
   output logic [CNT_WIDTH-1:0] stat_frames_bad
);

   // idle counter only ever holds 0..IDLE_CYCLES-1
   localparam int unsigned c_IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam int unsigned c_WIN_W  = $clog2(ERR_WINDOW);
   // wide enough to hold one pulse per cycle for a whole window
   localparam int unsigned c_ERR_W  = $clog2(ERR_WINDOW + 1);

   localparam logic [c_IDLE_W-1:0]  c_IDLE_ONE = 1;
   localparam logic [c_WIN_W-1:0]   c_WIN_ONE  = 1;
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = 1;

   typedef enum logic [1:0] {
      S_DISABLED  = 2'd0,
      S_WAIT_IDLE = 2'd1,
      S_ENABLED   = 2'd2,
      S_DRAIN     = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [c_IDLE_W-1:0]   r_idle_cnt;
   logic [c_IDLE_W-1:0]   w_idle_next;
   logic                  r_in_frame;
   logic                  r_cfg;
   logic                  r_fault;
   logic [c_WIN_W-1:0]    r_win_cnt;
   logic [c_ERR_W-1:0]    r_err_cnt;
   logic [CNT_WIDTH-1:0]  r_good;
   logic [CNT_WIDTH-1:0]  r_bad_fcs;
   logic [CNT_WIDTH-1:0]  r_bad;

   logic                  w_quiet;
   logic                  w_eop;
   logic                  w_wrap;
   logic [c_ERR_W-1:0]    w_err_base;
   logic [c_ERR_W-1:0]    w_err_sum;
   logic                  w_trip;

   function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + c_CNT_ONE;
   endfunction

   assign w_quiet = !mon_axis_tvalid && (mon_start_packet == 2'b00);
   assign w_eop   = mon_axis_tvalid && mon_axis_tlast;

   // The wrap cycle already belongs to the new window, so its pulse is
   // counted on top of a zero base rather than the old window's total.
   assign w_wrap     = (32'(r_win_cnt) == ERR_WINDOW - 1);
   assign w_err_base = w_wrap ? '0 : r_err_cnt;
   assign w_err_sum  = (&w_err_base) ? w_err_base
                     : w_err_base + {{(c_ERR_W-1){1'b0}}, mon_error_bad_frame};
   assign w_trip     = (r_state == S_ENABLED) && (ERR_THRESH != 0)
                     && (32'(w_err_sum) >= ERR_THRESH);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_DISABLED;
         r_idle_cnt <= '0;
         r_cfg      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_idle_cnt <= w_idle_next;
         // registered from the next state so cfg tracks the state register
         r_cfg      <= (w_state_next == S_ENABLED);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idle_next  = r_idle_cnt;
      case (r_state)
         S_DISABLED: begin
            if (rx_enable_req && !r_fault) begin
               w_state_next = S_WAIT_IDLE;
               w_idle_next  = '0;
            end
         end
         S_WAIT_IDLE: begin
            if (!rx_enable_req) begin
               w_state_next = S_DISABLED;
            end else if (!w_quiet) begin
               w_idle_next = '0;
            end else if (32'(r_idle_cnt) == IDLE_CYCLES - 1) begin
               w_state_next = S_ENABLED;
            end else begin
               w_idle_next = r_idle_cnt + c_IDLE_ONE;
            end
         end
         S_ENABLED: begin
            if (!rx_enable_req || w_trip) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // a frame already under way must see its tlast before disabling
            if (!r_in_frame && !mon_axis_tvalid) begin
               w_state_next = S_DISABLED;
            end
         end
         default: w_state_next = S_DISABLED;
      endcase
   end

   // ------------------------------------------------------ frame tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_frame <= 1'b0;
      end else if (mon_axis_tvalid) begin
         r_in_frame <= !mon_axis_tlast;
      end
   end

   // ------------------------------------------------ error window / fault
   always_ff @(posedge clk) begin
      if (rst) begin
         r_win_cnt <= '0;
         r_err_cnt <= '0;
         r_fault   <= 1'b0;
      end else begin
         r_win_cnt <= w_wrap ? '0 : r_win_cnt + c_WIN_ONE;
         r_err_cnt <= fault_clear ? '0 : w_err_sum;
         // a trip in the same cycle as fault_clear keeps the fault set
         if (w_trip) begin
            r_fault <= 1'b1;
         end else if (fault_clear) begin
            r_fault <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------- statistics
   always_ff @(posedge clk) begin
      if (rst || stat_clear) begin
         r_good    <= '0;
         r_bad_fcs <= '0;
         r_bad     <= '0;
      end else if (w_eop) begin
         if (!mon_error_bad_frame) begin
            r_good <= f_sat_inc(r_good);
         end
         if (mon_error_bad_fcs) begin
            r_bad_fcs <= f_sat_inc(r_bad_fcs);
         end
         if (mon_error_bad_frame && !mon_error_bad_fcs) begin
            r_bad <= f_sat_inc(r_bad);
         end
      end
   end

   assign cfg_rx_enable       = r_cfg;
   assign status_state        = r_state;
   assign status_rx_active    = (r_state != S_DISABLED);
   assign status_fault        = r_fault;
   assign stat_frames_good    = r_good;
   assign stat_frames_bad_fcs = r_bad_fcs;
   assign stat_frames_bad     = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_axis_xgmii_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_xgmii_rx_ctrl
// Purpose  : Self-checking bench for axis_xgmii_rx_ctrl. Directed scenarios
//            followed by randomized traffic, all compared every cycle against
//            a behavioural model of the enable/fault/statistics rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_xgmii_rx_ctrl;

   localparam int unsigned CW   = 4;
   localparam int unsigned IDLE = 16;
   localparam int unsigned WIN  = 64;
   localparam int unsigned TH   = 8;
   localparam int          CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic          fc  = 1'b0;
   logic          sc  = 1'b0;
   logic          tv  = 1'b0;
   logic          tl  = 1'b0;
   logic [1:0]    sp  = 2'b00;
   logic          bf  = 1'b0;
   logic          fcs = 1'b0;
   logic          cfg;
   logic [1:0]    st;
   logic          act;
   logic          flt;
   logic [CW-1:0] s_good;
   logic [CW-1:0] s_fcs;
   logic [CW-1:0] s_bad;

   axis_xgmii_rx_ctrl #(
      .CNT_WIDTH   (CW),
      .IDLE_CYCLES (IDLE),
      .ERR_WINDOW  (WIN),
      .ERR_THRESH  (TH)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .rx_enable_req       (req),
      .fault_clear         (fc),
      .stat_clear          (sc),
      .mon_axis_tvalid     (tv),
      .mon_axis_tlast      (tl),
      .mon_start_packet    (sp),
      .mon_error_bad_frame (bf),
      .mon_error_bad_fcs   (fcs),
      .cfg_rx_enable       (cfg),
      .status_state        (st),
      .status_rx_active    (act),
      .status_fault        (flt),
      .stat_frames_good    (s_good),
      .stat_frames_bad_fcs (s_fcs),
      .stat_frames_bad     (s_bad)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ------------------------------------------------------------- model
   int m_state, m_run, m_cfg, m_fault, m_inframe;
   int m_good, m_fcs, m_bad;
   int cyc;                 // edges since reset release
   int win_errs [int];      // bad-frame pulses per window index

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic model_edge();
      int  w, cnt, nxt;
      bit  quiet, trip;
      if (rst) begin
         m_state = 0; m_run = 0; m_cfg = 0; m_fault = 0; m_inframe = 0;
         m_good = 0; m_fcs = 0; m_bad = 0; cyc = 0;
         win_errs.delete();
         return;
      end
      quiet = !tv && (sp == 2'b00);
      // a pulse on the last phase of a window belongs to the next window
      w = (cyc + 1) / WIN;
      if (!win_errs.exists(w)) win_errs[w] = 0;
      cnt  = win_errs[w] + int'(bf);
      trip = (m_state == 2) && (TH != 0) && (cnt >= TH);
      nxt  = m_state;
      case (m_state)
         0: if (req && !m_fault) begin nxt = 1; m_run = 0; end
         1: begin
            if (!req) nxt = 0;
            else if (!quiet) m_run = 0;
            else begin
               m_run++;
               if (m_run >= IDLE) nxt = 2;
            end
         end
         2: if (!req || trip) nxt = 3;
         default: if (!m_inframe && !tv) nxt = 0;
      endcase
      if (trip) m_fault = 1;
      else if (fc) m_fault = 0;
      win_errs[w] = fc ? 0 : cnt;
      if (tv) m_inframe = !tl;
      if (sc) begin
         m_good = 0; m_fcs = 0; m_bad = 0;
      end else if (tv && tl) begin
         if (!bf)        m_good = sat(m_good + 1);
         if (fcs)        m_fcs  = sat(m_fcs + 1);
         if (bf && !fcs) m_bad  = sat(m_bad + 1);
      end
      m_state = nxt;
      m_cfg   = (nxt == 2);
      cyc++;
   endtask

   task automatic compare_all();
      check("state",  st,     m_state);
      check("cfg",    cfg,    m_cfg);
      check("active", act,    (m_state != 0));
      check("fault",  flt,    m_fault);
      check("good",   s_good, m_good);
      check("badfcs", s_fcs,  m_fcs);
      check("bad",    s_bad,  m_bad);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      fc = 0; sc = 0; tv = 0; tl = 0; sp = 2'b00; bf = 0; fcs = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      req = 0;
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   task automatic wait_cfg(input int limit, output int n);
      n = 0;
      while (n < limit) begin
         step();
         n++;
         if (cfg === 1'b1) break;
      end
   endtask

   task automatic single_beat(input bit bad, input bit bad_fcs);
      tv = 1; tl = 1; bf = bad; fcs = bad_fcs;
      step();
      idle_inputs();
   endtask

   // ---------------------------------------------------------- stimulus
   initial begin
      int n;
      int guard;
      int pv;

      // 1: reset state and enable latency on a quiet line
      do_reset();
      check("rst_state", st, 0);
      check("rst_cfg", cfg, 0);
      check("rst_fault", flt, 0);
      check("rst_good", s_good, 0);
      req = 1;
      wait_cfg(100, n);
      check("t1_latency", n, IDLE + 1);
      check("t1_state", st, 2);

      // 2: periodic start_packet keeps the line from looking quiet
      do_reset();
      req = 1;
      for (int i = 0; i <= 60; i++) begin
         sp = (i % 10 == 0) ? 2'b01 : 2'b00;
         step();
         check("t2_cfg_low", cfg, 0);
      end
      sp = 2'b00;
      wait_cfg(100, n);
      check("t2_latency", n, IDLE);

      // 3: request drops mid-frame, drain waits for tlast
      for (int b = 1; b <= 6; b++) begin
         tv = 1;
         tl = (b == 6);
         if (b == 2) req = 0;
         step();
         if (b >= 2) begin
            check("t3_drain_state", st, 3);
            check("t3_drain_cfg", cfg, 0);
         end
      end
      idle_inputs();
      step();
      check("t3_disabled", st, 0);
      check("t3_good", s_good, 1);

      // 4: error storm trips the fault; request ignored until cleared
      do_reset();
      req = 1;
      wait_cfg(100, n);
      check("t4_latency", n, IDLE + 1);
      for (int k = 0; k < 8; k++) begin
         single_beat(1'b1, 1'b1);
         check("t4_fault", flt, (k == 7));
         check("t4_state", st, (k == 7) ? 3 : 2);
      end
      step();
      check("t4_disabled", st, 0);
      check("t4_badfcs", s_fcs, 8);
      repeat (30) step();
      check("t4_held_state", st, 0);
      check("t4_held_fault", flt, 1);
      fc = 1;
      step();
      fc = 0;
      check("t4_cleared", flt, 0);
      wait_cfg(100, n);
      check("t4_reenable", n, IDLE + 1);

      // 5: window wrap resets the error count; wrap-cycle pulse starts the new one
      do_reset();
      req = 1;
      wait_cfg(100, n);
      for (int k = 0; k < 7; k++) single_beat(1'b1, 1'b0);
      guard = 0;
      while ((cyc % WIN) != WIN - 1 && guard < 2 * WIN) begin
         step();
         guard++;
      end
      check("t5_wrap_reached", (cyc % WIN), WIN - 1);
      single_beat(1'b1, 1'b0);
      check("t5_wrap_nofault", flt, 0);
      for (int k = 0; k < 6; k++) single_beat(1'b1, 1'b0);
      check("t5_seven_nofault", flt, 0);
      check("t5_still_enabled", st, 2);
      single_beat(1'b1, 1'b0);
      check("t5_eighth_trips", flt, 1);
      check("t5_bad_sat", s_bad, 15);

      // 6: counter saturation and stat_clear priority
      do_reset();
      for (int k = 0; k < 17; k++) single_beat(1'b0, 1'b0);
      check("t6_good_sat", s_good, CMAX);
      sc = 1; tv = 1; tl = 1;
      step();
      idle_inputs();
      check("t6_clear_wins", s_good, 0);
      single_beat(1'b0, 1'b0);
      check("t6_after_clear", s_good, 1);

      // randomized traffic with varying line activity
      do_reset();
      for (int seg = 0; seg < 30; seg++) begin
         case ($urandom_range(0, 2))
            0:       pv = 0;
            1:       pv = 15;
            default: pv = 60;
         endcase
         for (int i = 0; i < 100; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 39) == 0) req = !req;
            tv  = ($urandom_range(0, 99) < pv);
            tl  = tv && ($urandom_range(0, 2) == 0);
            sp  = (pv != 0 && $urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bf  = tl && ($urandom_range(0, 1) == 1);
            fcs = bf && ($urandom_range(0, 1) == 1);
            fc  = ($urandom_range(0, 63) == 0);
            sc  = ($urandom_range(0, 127) == 0);
            step();
         end
      end
      rst = 0;
      idle_inputs();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
